match_sequencer: RTL
====================

Name: match_sequencer

Overview:
Parametrised match-flow controller for the paddle game: owns serve/rally/point/endgame sequencing and both score counters. Successor to the fixed 21-point, loser-serves sequencer. Adds configurable target score, a serve-rotation mode, a hard score cap, a latched out-event interface and a synchronous restart. Sits between ballmover (out events, ball_reset) and the score display and sound blocks.

Parameters:
SCORE_W, 8, width of each binary score counter
WIN_SCORE, 21, points needed to win
CAP_SCORE, 30, hard cap: reaching it wins regardless of margin; must be >= WIN_SCORE and <= 2^SCORE_W-1
SERVE_PAUSE, 1024, ticks ball is held before each serve
SERVE_MODE, 0, 0 = loser of last point serves; 1 = serve alternates every SERVE_ROT points
SERVE_ROT, 2, points per server in mode 1
LED_DIV, 256, ticks per LED toggle in GAMEOVER
PAUSE_W, 12, width of pause counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  one-clk game-advance strobe (ballAdvance rate)
game_start  in  1  synchronous restart strobe
out_a  in  1  one-clk pulse: ball left via side A (point to B)
out_b  in  1  one-clk pulse: ball left via side B (point to A)
score_a  out  SCORE_W  side A score, binary
score_b  out  SCORE_W  side B score, binary
ball_reset  out  1  hold ball at serve position
service_side  out  1  0 = A serves, 1 = B serves
point_pulse  out  1  one clk high when a point is awarded
game_over  out  1  high in GAMEOVER
winner  out  1  0 = A, 1 = B; valid while game_over
led  out  1  status LED

Behaviour:
- Reset (reset low, async): state IDLE; scores 0, ball_reset 1, service_side 0, point_pulse 0, game_over 0, winner 0, led 0; pending flags and counters cleared.
- States: IDLE, SETUP, PAUSE, RALLY, GAMEOVER. Transitions occur only on clk edges with tick=1, except game_start.
- game_start, any state, any cycle: next clk goes to SETUP; scores 0; service_side 0; rotation counter 0; pending flags cleared. This has priority over tick and out events in the same cycle.
- Out latching: out_a/out_b set pend_a/pend_b on any clk while in RALLY, ignored in other states. Flags clear when consumed.
- SETUP (tick): ball_reset 1; pause <= SERVE_PAUSE-1; -> PAUSE.
- PAUSE (tick): if pause==0, ball_reset 0 and -> RALLY; else decrement. Ball is held exactly SERVE_PAUSE ticks.
- RALLY (tick, pend_a xor pend_b):
  - Award the point: pend_a -> score_b+1; pend_b -> score_a+1.
  - point_pulse is high for one clk.
  - Serve update. Mode 0: service_side <= pend_b. Mode 1: rotation count increments; when it reaches SERVE_ROT it wraps to 0 and service_side toggles.
  - Win check uses the post-increment scores (see Win rule). Win -> GAMEOVER with ball_reset 1 and led 1. Otherwise -> SETUP.
- RALLY, pend_a and pend_b both set on the same tick: let. No score change, no point_pulse, serve unchanged, -> SETUP.
- Win rule without WIN_BY_TWO_EN: the scorer wins when its new score == WIN_SCORE.
- GAMEOVER: scores frozen; further outs ignored; winner stable. led toggles every LED_DIV ticks. Exit only via game_start.
- IDLE: ball_reset 1, waits for game_start.
- Scores never exceed CAP_SCORE, so there is no wrap-around.
- All outputs are registered. Latency from an out pulse to the score update is the next tick edge.

Optional Feature:
WIN_BY_TWO_EN
- Defined: scorer wins when new score >= WIN_SCORE and leads by >= 2, or when new score == CAP_SCORE (lead >= 1 suffices).
- Undefined: first to WIN_SCORE wins, and CAP_SCORE is unused.

Test Plan:
- reset low mid-RALLY with score 5:3 -> immediately scores 0:0, ball_reset 1, state IDLE; after release, nothing happens until game_start.
- game_start, then tick every clk -> ball_reset falls exactly 1024+1 ticks after start (SETUP plus 1024 PAUSE ticks).
- Mode 0: out_b pulse in RALLY -> on next tick score_a=1, point_pulse for 1 clk, service_side=1. Then out_a -> score_b=1, service_side=0.
- Mode 1, SERVE_ROT=2: four consecutive points -> service_side sequence 0,1,1,0 after each point.
- out_a and out_b both latched before a tick -> scores unchanged, no point_pulse, back to SETUP.
- Without the macro, A reaches 21 at 20:20 -> game_over=1, winner=0, led toggles every 256 ticks. With WIN_BY_TWO_EN, 21:20 continues, 22:20 wins, and 30:29 wins at the cap.

Source files
------------

// File: rtl/match_sequencer.sv
// Match-flow controller: serve/rally/point/endgame sequencing and both score counters.
// Optional build macro WIN_BY_TWO_EN selects the win-by-two rule with a hard cap at CAP_SCORE.
module match_sequencer #(
   parameter int unsigned SCORE_W     = 8,
   parameter int unsigned WIN_SCORE   = 21,
   parameter int unsigned CAP_SCORE   = 30,
   parameter int unsigned SERVE_PAUSE = 1024,
   parameter int unsigned SERVE_MODE  = 0,
   parameter int unsigned SERVE_ROT   = 2,
   parameter int unsigned LED_DIV     = 256,
   parameter int unsigned PAUSE_W     = 12
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               game_start,
   input  logic               out_a,
   input  logic               out_b,
   output logic [SCORE_W-1:0] score_a,
   output logic [SCORE_W-1:0] score_b,
   output logic               ball_reset,
   output logic               service_side,
   output logic               point_pulse,
   output logic               game_over,
   output logic               winner,
   output logic               led
);

   localparam int unsigned LED_W = $clog2(LED_DIV) + 1;
   localparam int unsigned ROT_W = $clog2(SERVE_ROT) + 1;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      PAUSE,
      RALLY,
      GAMEOVER
   } state_e;

   state_e             state_q, state_d;
   logic [SCORE_W-1:0] score_a_q, score_a_d;
   logic [SCORE_W-1:0] score_b_q, score_b_d;
   logic               ball_reset_q, ball_reset_d;
   logic               service_side_q, service_side_d;
   logic               point_pulse_q, point_pulse_d;
   logic               game_over_q, game_over_d;
   logic               winner_q, winner_d;
   logic               led_q, led_d;
   logic               pend_a_q, pend_a_d;
   logic               pend_b_q, pend_b_d;
   logic [PAUSE_W-1:0] pause_q, pause_d;
   logic [LED_W-1:0]   led_cnt_q, led_cnt_d;
   logic [ROT_W-1:0]   rot_q, rot_d;

   logic [SCORE_W-1:0] inc_a, inc_b, scorer_new;
   logic               win;
`ifdef WIN_BY_TWO_EN
   logic [SCORE_W-1:0] scorer_other;
   logic [SCORE_W:0]   new_ext, lead_need;
`endif

   // Saturating increments keep scores at or below the cap even if the win rule never fires.
   assign inc_a      = (score_a_q >= SCORE_W'(CAP_SCORE)) ? score_a_q : score_a_q + 1'b1;
   assign inc_b      = (score_b_q >= SCORE_W'(CAP_SCORE)) ? score_b_q : score_b_q + 1'b1;
   assign scorer_new = pend_a_q ? inc_b : inc_a;

`ifdef WIN_BY_TWO_EN
   assign scorer_other = pend_a_q ? score_a_q : score_b_q;
   assign new_ext      = {1'b0, scorer_new};
   assign lead_need    = {1'b0, scorer_other} + (SCORE_W+1)'(2);
   assign win = ((new_ext >= (SCORE_W+1)'(WIN_SCORE)) && (new_ext >= lead_need))
             || (scorer_new == SCORE_W'(CAP_SCORE));
`else
   assign win = (scorer_new == SCORE_W'(WIN_SCORE));
`endif

   always_comb begin
      state_d        = state_q;
      score_a_d      = score_a_q;
      score_b_d      = score_b_q;
      ball_reset_d   = ball_reset_q;
      service_side_d = service_side_q;
      point_pulse_d  = 1'b0;
      game_over_d    = game_over_q;
      winner_d       = winner_q;
      led_d          = led_q;
      pend_a_d       = pend_a_q;
      pend_b_d       = pend_b_q;
      pause_d        = pause_q;
      led_cnt_d      = led_cnt_q;
      rot_d          = rot_q;

      if (state_q == RALLY) begin
         pend_a_d = pend_a_q | out_a;
         pend_b_d = pend_b_q | out_b;
      end

      if (game_start) begin
         state_d        = SETUP;
         score_a_d      = '0;
         score_b_d      = '0;
         ball_reset_d   = 1'b1;
         service_side_d = 1'b0;
         game_over_d    = 1'b0;
         winner_d       = 1'b0;
         led_d          = 1'b0;
         pend_a_d       = 1'b0;
         pend_b_d       = 1'b0;
         pause_d        = '0;
         led_cnt_d      = '0;
         rot_d          = '0;
      end else if (tick) begin
         case (state_q)
            IDLE: ball_reset_d = 1'b1;
            SETUP: begin
               ball_reset_d = 1'b1;
               pause_d      = PAUSE_W'(SERVE_PAUSE - 1);
               state_d      = PAUSE;
            end
            PAUSE: begin
               if (pause_q == '0) begin
                  ball_reset_d = 1'b0;
                  state_d      = RALLY;
               end else begin
                  pause_d = pause_q - 1'b1;
               end
            end
            RALLY: begin
               if (pend_a_q && pend_b_q) begin
                  pend_a_d     = 1'b0;
                  pend_b_d     = 1'b0;
                  ball_reset_d = 1'b1;
                  state_d      = SETUP;
               end else if (pend_a_q || pend_b_q) begin
                  pend_a_d      = 1'b0;
                  pend_b_d      = 1'b0;
                  point_pulse_d = 1'b1;
                  if (pend_a_q) score_b_d = inc_b;
                  else          score_a_d = inc_a;
                  if (SERVE_MODE == 0) begin
                     service_side_d = pend_b_q;
                  end else if (rot_q == ROT_W'(SERVE_ROT - 1)) begin
                     rot_d          = '0;
                     service_side_d = ~service_side_q;
                  end else begin
                     rot_d = rot_q + 1'b1;
                  end
                  ball_reset_d = 1'b1;
                  if (win) begin
                     state_d     = GAMEOVER;
                     game_over_d = 1'b1;
                     winner_d    = pend_a_q;
                     led_d       = 1'b1;
                     led_cnt_d   = '0;
                  end else begin
                     state_d = SETUP;
                  end
               end
            end
            GAMEOVER: begin
               if (led_cnt_q == LED_W'(LED_DIV - 1)) begin
                  led_cnt_d = '0;
                  led_d     = ~led_q;
               end else begin
                  led_cnt_d = led_cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         score_a_q      <= '0;
         score_b_q      <= '0;
         ball_reset_q   <= 1'b1;
         service_side_q <= 1'b0;
         point_pulse_q  <= 1'b0;
         game_over_q    <= 1'b0;
         winner_q       <= 1'b0;
         led_q          <= 1'b0;
         pend_a_q       <= 1'b0;
         pend_b_q       <= 1'b0;
         pause_q        <= '0;
         led_cnt_q      <= '0;
         rot_q          <= '0;
      end else begin
         state_q        <= state_d;
         score_a_q      <= score_a_d;
         score_b_q      <= score_b_d;
         ball_reset_q   <= ball_reset_d;
         service_side_q <= service_side_d;
         point_pulse_q  <= point_pulse_d;
         game_over_q    <= game_over_d;
         winner_q       <= winner_d;
         led_q          <= led_d;
         pend_a_q       <= pend_a_d;
         pend_b_q       <= pend_b_d;
         pause_q        <= pause_d;
         led_cnt_q      <= led_cnt_d;
         rot_q          <= rot_d;
      end
   end

   assign score_a      = score_a_q;
   assign score_b      = score_b_q;
   assign ball_reset   = ball_reset_q;
   assign service_side = service_side_q;
   assign point_pulse  = point_pulse_q;
   assign game_over    = game_over_q;
   assign winner       = winner_q;
   assign led          = led_q;

endmodule
